reg_rename_file: RTL and testbench
==================================

// Module: reg_rename_file
// PURPOSE
// Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer.
// Consumes the ROB head broadcast (cdb_tag/cdb_val/cdb_active), retires values in program order, and returns a pop strobe to the ROB.
// Serves issue-stage operand reads as either a ready value or a pending ROB tag, and records dest-register renames from issue.
// PARAMETERS
// XLEN      32  data width
// REG_NUM   32  architectural registers; x0 hardwired to zero
// TAG_W     4   ROB tag width; tag space = 2**TAG_W = `ROB_SIZE
// PORTS
// clk_in        in   1      clock
// rst_in        in   1      synchronous reset, active-high
// rdy_in        in   1      global ready; 0 = hold all state, commit_pop = 0
// rename_valid  in   1      issue allocates dest reg this cycle
// rename_rd     in   5      dest register index
// rename_tag    in   TAG_W  ROB tag assigned to that instruction
// rs1_idx       in   5      operand-1 register index
// rs2_idx       in   5      operand-2 register index
// rs1_val       out  XLEN   operand-1 value (valid when rs1_busy = 0)
// rs1_tag       out  TAG_W  operand-1 producer tag (valid when rs1_busy = 1)
// rs1_busy      out  1      operand-1 still pending
// rs2_val/rs2_tag/rs2_busy  out  XLEN/TAG_W/1  same for operand 2
// cdb_tag       in   TAG_W  ROB head tag
// cdb_val       in   XLEN   ROB head result
// cdb_active    in   1      ROB head solved, ready to retire
// predict_fail  in   1      flush from branch predictor
// commit_pop    out  1      head retired this cycle; ROB advances front
// BEHAVIOUR
// - State: regs[REG_NUM] (XLEN), busy[REG_NUM], tag[REG_NUM] (TAG_W), tag_rd[2**TAG_W] (5-bit tag->rd map).
// - Reset (rst_in=1 at posedge): all regs = 0, busy = 0, tag = 0, tag_rd = 0; outputs reflect that next cycle (busy=0, val=0, commit_pop=0).
// - rdy_in=0: no state change; commit_pop = 0; reads still combinational.
// - Rename (rename_valid & rdy_in & !predict_fail): if rename_rd != 0 -> busy[rd]<=1, tag[rd]<=rename_tag, tag_rd[rename_tag]<=rename_rd; rd=0 ignored except tag_rd write.
// - Commit (cdb_active & rdy_in): rd = tag_rd[cdb_tag]; if rd != 0, regs[rd] <= cdb_val; busy[rd] <= 0 only if tag[rd]==cdb_tag and rd not renamed this cycle.
// - commit_pop = cdb_active & rdy_in (combinational, same cycle as write); exactly one retire per cycle.
// - Read (combinational): idx=0 -> val 0, busy 0. busy[idx]=0 -> val=regs[idx]. busy[idx]=1 and cdb_active and tag[idx]==cdb_tag -> bypass: val=cdb_val, busy 0.
//   Otherwise busy 1, tag=tag[idx]. Reads see pre-rename state of current cycle (rename visible next cycle).
// - Simultaneous rename & commit, same rd: value written, rename wins (busy stays 1, new tag).
// - predict_fail & rdy_in: commit of the head still performed (head is older than the mispredicted branch);
//   then all busy <= 0, rename ignored; regs keep committed values. tag_rd not cleared (stale entries harmless since ROB restarts at tag slots re-written on rename).
// - Tag wrap: tags reused after 2**TAG_W allocations; the tag-match check on commit protects newer renames.
// STRUCTURE
// - `XLEN, `REG_NUM, `TAG_W, `ROB_SIZE constants in src/macros.v (shared with ReorderBuffer).
// - One sub-module natural: operand_read_port (one instance per rs: idx-zero, busy, CDB-bypass mux).
// - Single clocked always block for regs/busy/tag/tag_rd; reads and commit_pop combinational.
// TESTING
// - Reset then rs1_idx=5 -> rs1_busy=0, rs1_val=0; commit_pop=0.
// - Rename x5 tag 3; next cycle rs1_idx=5 -> busy=1, tag=3; cdb tag 3 val 0xDEADBEEF active -> same-cycle bypass val 0xDEADBEEF busy 0, commit_pop=1; next cycle regs[5]=0xDEADBEEF busy 0.
// - Rename x7 tag 1, then x7 tag 2; commit tag 1 val 0x11 -> regs[7]=0x11 but busy=1 tag=2; commit tag 2 val 0x22 -> busy 0, val 0x22.
// - Rename x0 tag 4; commit tag 4 val 0x55 -> rs1_idx=0 reads 0, busy 0; commit_pop=1.
// - Rename x3 tag 6, x4 tag 7; predict_fail with cdb tag 6 val 0x66 active -> regs[3]=0x66; x3,x4 busy=0; x4 keeps old value.
// - rdy_in=0 with cdb_active and rename_valid -> no state change, commit_pop=0; rdy_in back to 1 -> both applied.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// rtl/reg_rename_file_pkg.sv - shared widths for the rename register file
package reg_rename_file_pkg;
    localparam int XLEN     = 32;
    localparam int REG_NUM  = 32;
    localparam int TAG_W    = 4;
    localparam int ROB_SIZE = 2 ** TAG_W;
    localparam int RD_W     = $clog2(REG_NUM);
endpackage

// File: rtl/reg_rename_file_read_port.sv
// rtl/reg_rename_file_read_port.sv - one operand read: x0, pending tag or CDB bypass
module reg_rename_file_read_port
    import reg_rename_file_pkg::*;
(
    input  logic [RD_W-1:0]  i_idx,
    input  logic [XLEN-1:0]  i_reg_val,
    input  logic             i_busy,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_cdb_active,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [XLEN-1:0]  i_cdb_val,
    output logic [XLEN-1:0]  o_val,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);
    always_comb begin
        o_val  = i_reg_val;
        o_tag  = i_tag;
        o_busy = 1'b0;
        if (i_idx == '0) begin
            o_val = '0;
        end else if (i_busy) begin
            // The producer retiring right now supplies the value directly
            if (i_cdb_active && (i_tag == i_cdb_tag)) begin
                o_val = i_cdb_val;
            end else begin
                o_busy = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with rename tags, retiring from the ROB head
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rename_valid,
    input  logic [RD_W-1:0]  rename_rd,
    input  logic [TAG_W-1:0] rename_tag,
    input  logic [RD_W-1:0]  rs1_idx,
    input  logic [RD_W-1:0]  rs2_idx,
    output logic [XLEN-1:0]  rs1_val,
    output logic [TAG_W-1:0] rs1_tag,
    output logic             rs1_busy,
    output logic [XLEN-1:0]  rs2_val,
    output logic [TAG_W-1:0] rs2_tag,
    output logic             rs2_busy,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_val,
    input  logic             cdb_active,
    input  logic             predict_fail,
    output logic             commit_pop
);
    logic [XLEN-1:0]  r_regs   [REG_NUM];
    logic [REG_NUM-1:0] r_busy;
    logic [TAG_W-1:0] r_tag    [REG_NUM];
    logic [RD_W-1:0]  r_tag_rd [ROB_SIZE];

    logic             w_commit;
    logic             w_rename;
    logic [RD_W-1:0]  w_commit_rd;

    assign w_commit    = cdb_active & rdy_in;
    assign w_rename    = rename_valid & rdy_in & ~predict_fail;
    assign w_commit_rd = r_tag_rd[cdb_tag];
    assign commit_pop  = w_commit;

    // Later assignments override: rename beats commit on busy, flush beats both
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
            for (int t = 0; t < ROB_SIZE; t++) begin
                r_tag_rd[t] <= '0;
            end
            r_busy <= '0;
        end else if (rdy_in) begin
            if (w_commit && (w_commit_rd != '0)) begin
                r_regs[w_commit_rd] <= cdb_val;
                if (r_tag[w_commit_rd] == cdb_tag) begin
                    r_busy[w_commit_rd] <= 1'b0;
                end
            end
            if (w_rename) begin
                if (rename_rd != '0) begin
                    r_busy[rename_rd] <= 1'b1;
                    r_tag[rename_rd]  <= rename_tag;
                end
                r_tag_rd[rename_tag] <= rename_rd;
            end
            if (predict_fail) begin
                r_busy <= '0;
            end
        end
    end

    reg_rename_file_read_port u_rs1 (
        .i_idx        (rs1_idx),
        .i_reg_val    (r_regs[rs1_idx]),
        .i_busy       (r_busy[rs1_idx]),
        .i_tag        (r_tag[rs1_idx]),
        .i_cdb_active (cdb_active),
        .i_cdb_tag    (cdb_tag),
        .i_cdb_val    (cdb_val),
        .o_val        (rs1_val),
        .o_tag        (rs1_tag),
        .o_busy       (rs1_busy)
    );

    reg_rename_file_read_port u_rs2 (
        .i_idx        (rs2_idx),
        .i_reg_val    (r_regs[rs2_idx]),
        .i_busy       (r_busy[rs2_idx]),
        .i_tag        (r_tag[rs2_idx]),
        .i_cdb_active (cdb_active),
        .i_cdb_tag    (cdb_tag),
        .i_cdb_val    (cdb_val),
        .o_val        (rs2_val),
        .o_tag        (rs2_tag),
        .o_busy       (rs2_busy)
    );
endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - directed and randomized checks of reg_rename_file against a reference model
module tb_reg_rename_file;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rename_valid, cdb_active, predict_fail;
    logic [4:0]  rename_rd, rs1_idx, rs2_idx;
    logic [3:0]  rename_tag, cdb_tag;
    logic [31:0] cdb_val;
    logic [31:0] rs1_val, rs2_val;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        rs1_busy, rs2_busy, commit_pop;

    int checks = 0;
    int errors = 0;

    // Reference state, held as plain arrays
    logic [31:0] m_regs   [32];
    bit          m_busy   [32];
    logic [3:0]  m_tag    [32];
    logic [4:0]  m_tag_rd [16];

    always #5 clk_in = ~clk_in;

    reg_rename_file dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rename_valid (rename_valid),
        .rename_rd    (rename_rd),
        .rename_tag   (rename_tag),
        .rs1_idx      (rs1_idx),
        .rs2_idx      (rs2_idx),
        .rs1_val      (rs1_val),
        .rs1_tag      (rs1_tag),
        .rs1_busy     (rs1_busy),
        .rs2_val      (rs2_val),
        .rs2_tag      (rs2_tag),
        .rs2_busy     (rs2_busy),
        .cdb_tag      (cdb_tag),
        .cdb_val      (cdb_val),
        .cdb_active   (cdb_active),
        .predict_fail (predict_fail),
        .commit_pop   (commit_pop)
    );

    task automatic model_clock();
        int  crd;
        bit  ren;
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
                m_tag[i]  = 4'd0;
            end
            for (int t = 0; t < 16; t++) m_tag_rd[t] = 5'd0;
        end else if (rdy_in) begin
            crd = int'(m_tag_rd[cdb_tag]);
            ren = rename_valid && !predict_fail;
            if (cdb_active && crd != 0) begin
                m_regs[crd] = cdb_val;
                if (m_tag[crd] == cdb_tag && !(ren && int'(rename_rd) == crd)) m_busy[crd] = 1'b0;
            end
            if (ren) begin
                if (rename_rd != 5'd0) begin
                    m_busy[rename_rd] = 1'b1;
                    m_tag[rename_rd]  = rename_tag;
                end
                m_tag_rd[rename_tag] = rename_rd;
            end
            if (predict_fail) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end
    endtask

    function automatic void model_read(input logic [4:0] idx, output logic [31:0] v,
                                       output logic [3:0] t, output logic b);
        v = m_regs[idx];
        t = m_tag[idx];
        b = 1'b0;
        if (idx == 5'd0) v = 32'd0;
        else if (m_busy[idx] && cdb_active && m_tag[idx] == cdb_tag) v = cdb_val;
        else if (m_busy[idx]) b = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk_in);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; rename_valid = 1'b0; cdb_active = 1'b0;
        predict_fail = 1'b0; rename_rd = 5'd0; rename_tag = 4'd0; cdb_tag = 4'd0; cdb_val = 32'd0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] tg);
        idle(); rename_valid = 1'b1; rename_rd = rd; rename_tag = tg; step();
    endtask

    task automatic test_reset();
        idle(); rst_in = 1'b1; rs1_idx = 5'd5; rs2_idx = 5'd31;
        step();
        idle(); #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'd0) begin
            errors++; $display("FAIL reset_rs1: busy=%0b val=%h, expected busy=0 val=0", rs1_busy, rs1_val);
        end
        checks++;
        if (rs2_busy !== 1'b0 || rs2_val !== 32'd0) begin
            errors++; $display("FAIL reset_rs2: busy=%0b val=%h, expected busy=0 val=0", rs2_busy, rs2_val);
        end
        checks++;
        if (commit_pop !== 1'b0) begin
            errors++; $display("FAIL reset_pop: commit_pop=%0b, expected 0", commit_pop);
        end
    endtask

    task automatic test_bypass();
        do_rename(5'd5, 4'd3);
        idle(); rs1_idx = 5'd5; #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd3) begin
            errors++; $display("FAIL bypass_pending: busy=%0b tag=%0d, expected busy=1 tag=3", rs1_busy, rs1_tag);
        end
        cdb_active = 1'b1; cdb_tag = 4'd3; cdb_val = 32'hDEADBEEF; #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'hDEADBEEF || commit_pop !== 1'b1) begin
            errors++; $display("FAIL bypass_same_cycle: busy=%0b val=%h pop=%0b, expected busy=0 val=deadbeef pop=1",
                               rs1_busy, rs1_val, commit_pop);
        end
        step();
        idle(); #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_committed: busy=%0b val=%h, expected busy=0 val=deadbeef", rs1_busy, rs1_val);
        end
    endtask

    task automatic test_tag_reuse();
        do_rename(5'd7, 4'd1);
        do_rename(5'd7, 4'd2);
        idle(); rs1_idx = 5'd7; cdb_active = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h11; #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd2) begin
            errors++; $display("FAIL stale_commit_nobypass: busy=%0b tag=%0d, expected busy=1 tag=2", rs1_busy, rs1_tag);
        end
        step();
        idle(); #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd2) begin
            errors++; $display("FAIL stale_commit_keeps_busy: busy=%0b tag=%0d, expected busy=1 tag=2", rs1_busy, rs1_tag);
        end
        cdb_active = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h22;
        step();
        idle(); #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'h22) begin
            errors++; $display("FAIL newest_commit: busy=%0b val=%h, expected busy=0 val=22", rs1_busy, rs1_val);
        end
    endtask

    task automatic test_x0();
        do_rename(5'd0, 4'd4);
        idle(); rs1_idx = 5'd0; cdb_active = 1'b1; cdb_tag = 4'd4; cdb_val = 32'h55; #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'd0 || commit_pop !== 1'b1) begin
            errors++; $display("FAIL x0_commit: busy=%0b val=%h pop=%0b, expected busy=0 val=0 pop=1",
                               rs1_busy, rs1_val, commit_pop);
        end
        step();
        idle(); #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'd0) begin
            errors++; $display("FAIL x0_after: busy=%0b val=%h, expected busy=0 val=0", rs1_busy, rs1_val);
        end
    endtask

    task automatic test_flush();
        do_rename(5'd4, 4'd10);
        idle(); cdb_active = 1'b1; cdb_tag = 4'd10; cdb_val = 32'h44; step();
        do_rename(5'd3, 4'd6);
        do_rename(5'd4, 4'd7);
        idle(); predict_fail = 1'b1; cdb_active = 1'b1; cdb_tag = 4'd6; cdb_val = 32'h66;
        rename_valid = 1'b1; rename_rd = 5'd9; rename_tag = 4'd8;
        step();
        idle(); rs1_idx = 5'd3; rs2_idx = 5'd4; #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs1_val !== 32'h66) begin
            errors++; $display("FAIL flush_head_commit: busy=%0b val=%h, expected busy=0 val=66", rs1_busy, rs1_val);
        end
        checks++;
        if (rs2_busy !== 1'b0 || rs2_val !== 32'h44) begin
            errors++; $display("FAIL flush_keeps_old: busy=%0b val=%h, expected busy=0 val=44", rs2_busy, rs2_val);
        end
        rs1_idx = 5'd9; #1;
        checks++;
        if (rs1_busy !== 1'b0) begin
            errors++; $display("FAIL flush_drops_rename: busy=%0b, expected 0", rs1_busy);
        end
    endtask

    task automatic test_stall();
        do_rename(5'd11, 4'd5);
        idle(); rdy_in = 1'b0; cdb_active = 1'b1; cdb_tag = 4'd5; cdb_val = 32'hAB;
        rename_valid = 1'b1; rename_rd = 5'd10; rename_tag = 4'd9; rs1_idx = 5'd10; rs2_idx = 5'd12; #1;
        checks++;
        if (commit_pop !== 1'b0) begin
            errors++; $display("FAIL stall_pop: commit_pop=%0b, expected 0", commit_pop);
        end
        step();
        cdb_active = 1'b0; rs1_idx = 5'd10; rs2_idx = 5'd11; #1;
        checks++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1 || rs2_tag !== 4'd5) begin
            errors++; $display("FAIL stall_hold: x10 busy=%0b x11 busy=%0b tag=%0d, expected 0 1 5",
                               rs1_busy, rs2_busy, rs2_tag);
        end
        rdy_in = 1'b1; cdb_active = 1'b1; #1;
        checks++;
        if (commit_pop !== 1'b1) begin
            errors++; $display("FAIL resume_pop: commit_pop=%0b, expected 1", commit_pop);
        end
        step();
        idle(); #1;
        checks++;
        if (rs1_busy !== 1'b1 || rs1_tag !== 4'd9 || rs2_busy !== 1'b0 || rs2_val !== 32'hAB) begin
            errors++; $display("FAIL resume_apply: x10 busy=%0b tag=%0d x11 busy=%0b val=%h, expected 1 9 0 ab",
                               rs1_busy, rs1_tag, rs2_busy, rs2_val);
        end
    endtask

    task automatic test_random();
        logic [31:0] ev;
        logic [3:0]  et;
        logic        eb;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_in       = ($urandom_range(0, 199) == 0);
            rdy_in       = ($urandom_range(0, 9) != 0);
            rename_valid = $urandom_range(0, 1) == 1;
            rename_rd    = 5'($urandom_range(0, 31));
            rename_tag   = 4'($urandom_range(0, 15));
            cdb_active   = ($urandom_range(0, 9) < 4);
            cdb_tag      = 4'($urandom_range(0, 15));
            cdb_val      = $urandom;
            predict_fail = ($urandom_range(0, 24) == 0);
            rs1_idx      = 5'($urandom_range(0, 31));
            rs2_idx      = 5'($urandom_range(0, 31));
            #1;
            model_read(rs1_idx, ev, et, eb);
            checks++;
            if (rs1_busy !== eb || (!eb && rs1_val !== ev) || (eb && rs1_tag !== et)) begin
                errors++; $display("FAIL rand_rs1 cyc %0d x%0d: busy=%0b val=%h tag=%0d, expected busy=%0b val=%h tag=%0d",
                                   cyc, rs1_idx, rs1_busy, rs1_val, rs1_tag, eb, ev, et);
            end
            model_read(rs2_idx, ev, et, eb);
            checks++;
            if (rs2_busy !== eb || (!eb && rs2_val !== ev) || (eb && rs2_tag !== et)) begin
                errors++; $display("FAIL rand_rs2 cyc %0d x%0d: busy=%0b val=%h tag=%0d, expected busy=%0b val=%h tag=%0d",
                                   cyc, rs2_idx, rs2_busy, rs2_val, rs2_tag, eb, ev, et);
            end
            checks++;
            if (commit_pop !== (cdb_active && rdy_in)) begin
                errors++; $display("FAIL rand_pop cyc %0d: commit_pop=%0b, expected %0b",
                                   cyc, commit_pop, cdb_active && rdy_in);
            end
            step();
        end
    endtask

    initial begin
        idle(); rs1_idx = 5'd0; rs2_idx = 5'd0;
        test_reset();
        test_bypass();
        test_tag_reuse();
        test_x0();
        test_flush();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
